// File: rtl/filt_seq_ctrl.sv
// Frame sequencer for the 1-bit FIR stage: counts bit strobes, snapshots the buffer once
// per decimation frame, steps the MAC through every tap group and pushes the result.
module filt_seq_ctrl #(
   parameter int TAPS    = 512,
   parameter int LANES   = 4,
   parameter int DECIM   = 32,
   parameter int MAC_LAT = 2,
   parameter int AW      = $clog2(TAPS / LANES)
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          Enable,
   input  logic          BitIn,
   input  logic [15:0]   Acc,
   input  logic          PushReady,
   input  logic          OvrClr,
   output logic          Filter,
   output logic [AW-1:0] TapAddr,
   output logic          AccClr,
   output logic          AccEn,
   output logic [15:0]   Dout,
   output logic          Push,
   output logic          Busy,
   output logic          Overrun
);
   localparam int BEATS = TAPS / LANES;
   localparam int CW    = $clog2(DECIM);
   localparam int DW    = $clog2(MAC_LAT + 2);
   localparam logic [AW-1:0] LAST_BEAT  = AW'(BEATS - 1);
   localparam logic [CW-1:0] LAST_BIT   = CW'(DECIM - 1);
   localparam logic [DW-1:0] LAST_DRAIN = DW'(MAC_LAT);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SNAP  = 3'd1,
      MAC   = 3'd2,
      DRAIN = 3'd3,
      PUSH  = 3'd4
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [CW-1:0]   bit_cnt_r;
   logic [CW-1:0]   bit_cnt_s;
   logic [DW-1:0]   drain_cnt_r;
   logic [DW-1:0]   drain_cnt_s;
   logic            tick_s;
   logic            handshake_s;
   logic            drop_s;
   logic            filter_s;
   logic [AW-1:0]   tap_s;
   logic            acc_clr_s;
   logic            acc_en_s;
   logic [15:0]     dout_s;
   logic            push_s;
   logic            busy_s;
   logic            overrun_s;

   // Frame tick and push handshake decode
   always_comb begin
      tick_s      = BitIn && Enable && (bit_cnt_r == LAST_BIT);
      handshake_s = Push && PushReady;
   end

   // Bit strobe counter: Enable low parks it at zero
   always_comb begin
      bit_cnt_s = bit_cnt_r;
      if (!Enable) begin
         bit_cnt_s = {CW{1'b0}};
      end else if (BitIn) begin
         if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_s = {CW{1'b0}};
         end else begin
            bit_cnt_s = bit_cnt_r + CW'(1'b1);
         end
      end else begin
         bit_cnt_s = bit_cnt_r;
      end
   end

   // Next state and next registered outputs
   always_comb begin
      state_s     = state_r;
      drain_cnt_s = {DW{1'b0}};
      drop_s      = 1'b0;
      filter_s    = 1'b0;
      tap_s       = {AW{1'b0}};
      acc_clr_s   = 1'b0;
      acc_en_s    = 1'b0;
      dout_s      = Dout;
      push_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (tick_s) begin
               state_s  = SNAP;
               filter_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         SNAP: begin
            drop_s    = tick_s;
            state_s   = MAC;
            acc_en_s  = 1'b1;
            acc_clr_s = 1'b1;
         end
         MAC: begin
            drop_s = tick_s;
            if (TapAddr == LAST_BEAT) begin
               state_s = DRAIN;
            end else begin
               state_s  = MAC;
               acc_en_s = 1'b1;
               tap_s    = TapAddr + AW'(1'b1);
            end
         end
         // The MAC registers the last beat one edge after AccEn drops, so the drain
         // runs MAC_LAT+1 cycles before Acc is sampled.
         DRAIN: begin
            drop_s = tick_s;
            if (drain_cnt_r == LAST_DRAIN) begin
               state_s = PUSH;
               push_s  = 1'b1;
               dout_s  = Acc;
            end else begin
               state_s     = DRAIN;
               drain_cnt_s = drain_cnt_r + DW'(1'b1);
            end
         end
         PUSH: begin
            if (handshake_s) begin
               if (tick_s) begin
                  state_s  = SNAP;
                  filter_s = 1'b1;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               drop_s  = tick_s;
               state_s = PUSH;
               push_s  = 1'b1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      busy_s = (state_s != IDLE);
      if (drop_s) begin
         overrun_s = 1'b1;
      end else if (OvrClr) begin
         overrun_s = 1'b0;
      end else begin
         overrun_s = Overrun;
      end
   end

   // State, counters and all outputs
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_r     <= IDLE;
         bit_cnt_r   <= {CW{1'b0}};
         drain_cnt_r <= {DW{1'b0}};
         Filter      <= 1'b0;
         TapAddr     <= {AW{1'b0}};
         AccClr      <= 1'b0;
         AccEn       <= 1'b0;
         Dout        <= 16'h0000;
         Push        <= 1'b0;
         Busy        <= 1'b0;
         Overrun     <= 1'b0;
      end else begin
         state_r     <= state_s;
         bit_cnt_r   <= bit_cnt_s;
         drain_cnt_r <= drain_cnt_s;
         Filter      <= filter_s;
         TapAddr     <= tap_s;
         AccClr      <= acc_clr_s;
         AccEn       <= acc_en_s;
         Dout        <= dout_s;
         Push        <= push_s;
         Busy        <= busy_s;
         Overrun     <= overrun_s;
      end
   end
endmodule
